// File: rtl/seq_divider32_pkg.sv
// ----------------------------------------------------------------------------
// seq_divider32_pkg
// Shared definitions for the iterative divider: FSM state encoding, the
// iteration counter width helper and the fill bit used to build the
// divide-by-zero quotient constant.
// No ports (package).
// ----------------------------------------------------------------------------
package seq_divider32_pkg;

    // IDLE waits for start, CALC runs one quotient bit per edge,
    // FIX applies the sign correction and registers the results.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Replicated WIDTH times to form the all-ones divide-by-zero quotient.
    localparam logic DIV0_FILL = 1'b1;

    // Counter must hold 0..width-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider32_div_step.sv
// ----------------------------------------------------------------------------
// seq_divider32_div_step
// One combinational iteration of restoring division.
// Ports:
//   rem       in  WIDTH  partial remainder before this step
//   msb       in  1      dividend bit shifted into the remainder
//   divisor   in  WIDTH  divisor magnitude
//   next_rem  out WIDTH  partial remainder after this step
//   q_bit     out 1      quotient bit produced by this step
// ----------------------------------------------------------------------------
module seq_divider32_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor always holds, so shifted < 2*divisor and the difference
    // fits a WIDTH+1 bit two's-complement value; its top bit is the borrow.
    always_comb begin
        shifted  = {rem, msb};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider32.sv
// ----------------------------------------------------------------------------
// seq_divider32
// Iterative restoring integer divider, one quotient bit per clock, signed or
// unsigned. Issue with start, stall while busy, capture results on done.
// Ports:
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   start         in   1      issue request (accepted only in IDLE)
//   isSigned      in   1      1 = two's-complement division
//   leftOperand   in   WIDTH  dividend
//   rightOperand  in   WIDTH  divisor
//   busy          out  1      operation in flight
//   done          out  1      one-cycle pulse, results valid
//   quotient      out  WIDTH  registered quotient
//   remainder     out  WIDTH  registered remainder
//   divByZero     out  1      registered divide-by-zero flag
// ----------------------------------------------------------------------------
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] leftOperand,
    input  logic [WIDTH-1:0] rightOperand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg;
    logic             r_neg;
    logic             div0_q;
    logic [CNT_W-1:0] count;

    logic             left_neg;
    logic             right_neg;
    logic [WIDTH-1:0] left_mag;
    logic [WIDTH-1:0] right_mag;
    logic             right_zero;
    logic             last_iter;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    // Operand magnitudes and sign bits used at issue time. In signed mode the
    // most negative value maps to itself, which is the correct unsigned
    // magnitude, so MIN / -1 needs no special handling.
    always_comb begin
        left_neg   = isSigned & leftOperand[WIDTH-1];
        right_neg  = isSigned & rightOperand[WIDTH-1];
        left_mag   = left_neg ? (~leftOperand + 1'b1) : leftOperand;
        right_mag  = right_neg ? (~rightOperand + 1'b1) : rightOperand;
        right_zero = (rightOperand == '0);
        last_iter  = (count == CNT_W'(WIDTH - 1));
    end

    seq_divider32_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .msb      (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .next_rem (step_rem),
        .q_bit    (step_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a zero divisor skips straight to FIX.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = right_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Busy covers CALC and FIX; in the done cycle the FSM is back in IDLE.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Datapath. The dividend register doubles as the quotient shift register;
    // on a zero divisor it keeps the raw dividend so it can be returned as
    // the remainder unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div0_q    <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem_q     <= '0;
                        count     <= '0;
                        dvs_q     <= right_mag;
                        dvd_q     <= right_zero ? leftOperand : left_mag;
                        div0_q    <= right_zero;
                        q_neg     <= left_neg ^ right_neg;
                        r_neg     <= left_neg;
                        divByZero <= 1'b0;
                    end
                end
                S_CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_bit};
                    count <= count + CNT_W'(1);
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (div0_q) begin
                        quotient  <= {WIDTH{DIV0_FILL}};
                        remainder <= dvd_q;
                        divByZero <= 1'b1;
                    end else begin
                        quotient  <= q_neg ? (~dvd_q + 1'b1) : dvd_q;
                        remainder <= r_neg ? (~rem_q + 1'b1) : rem_q;
                        divByZero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
